// File: rtl/tile_reader.sv
// Scratchpad-to-lane broadcast transmitter: walks an inclusive word-address range,
// reads the scratchpad and holds each word on the lane bus until every enabled lane can take it.
module tile_reader #(
    parameter int SPAD_DATA_WIDTH = 64,
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 8,
    parameter int SPAD_N          = SPAD_DATA_WIDTH / DATA_WIDTH,
    parameter int N_LANES         = 4
) (
    input  logic                       i_clk,
    input  logic                       i_nrst,
    input  logic                       i_reg_clear,
    input  logic                       i_start,
    input  logic [ADDR_WIDTH-1:0]      i_start_addr,
    input  logic [ADDR_WIDTH-1:0]      i_end_addr,
    input  logic [N_LANES-1:0]         i_lane_en,
    input  logic [N_LANES-1:0]         i_lane_full,
    input  logic [N_LANES-1:0]         i_lane_route_done,
    output logic                       o_spad_read_en,
    output logic [ADDR_WIDTH-1:0]      o_spad_addr,
    input  logic [SPAD_DATA_WIDTH-1:0] i_spad_data,
    output logic [SPAD_DATA_WIDTH-1:0] o_data,
    output logic [ADDR_WIDTH-1:0]      o_addr,
    output logic                       o_data_valid,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [ADDR_WIDTH-1:0]      o_word_count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t                       state_q, state_d;
    logic [ADDR_WIDTH-1:0]        ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]        end_q, end_d;
    logic [N_LANES-1:0]           mask_q, mask_d;
    logic [SPAD_DATA_WIDTH-1:0]   data_q, data_d;
    logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]        count_q, count_d;
    logic                         accept_s;
    logic                         all_done_s;
    logic                         rd_en_s;
    logic [ADDR_WIDTH-1:0]        rd_addr_s;

    // Next-state, datapath updates and the scratchpad read strobe.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        end_d      = end_q;
        mask_d     = mask_q;
        data_d     = data_q;
        addr_d     = addr_q;
        count_d    = count_q;
        rd_en_s    = 1'b0;
        rd_addr_s  = '0;
        accept_s   = (state_q == ST_SEND) && !(|(i_lane_full & mask_q));
        all_done_s = &(i_lane_route_done | ~mask_q);

        if (i_reg_clear) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
            end_d   = '0;
            mask_d  = '0;
            data_d  = '0;
            addr_d  = '0;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        ptr_d   = i_start_addr;
                        end_d   = i_end_addr;
                        mask_d  = i_lane_en;
                        count_d = '0;
                        if (i_start_addr > i_end_addr) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_FETCH: begin
                    if (all_done_s) begin
                        state_d = ST_DONE;
                    end else begin
                        rd_en_s   = 1'b1;
                        rd_addr_s = ptr_q;
                        state_d   = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    data_d  = i_spad_data;
                    addr_d  = ptr_q;
                    state_d = ST_SEND;
                end
                ST_SEND: begin
                    // The end compare precedes the increment, so ptr never wraps.
                    if (accept_s) begin
                        count_d = count_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                        if (addr_q == end_q) begin
                            state_d = ST_DONE;
                        end else begin
                            ptr_d = ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                            if (all_done_s) begin
                                state_d = ST_DONE;
                            end else begin
                                rd_en_s   = 1'b1;
                                rd_addr_s = ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                                state_d   = ST_CAPTURE;
                            end
                        end
                    end else begin
                        state_d = ST_SEND;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            end_q   <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            end_q   <= end_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

    assign o_spad_read_en = rd_en_s;
    assign o_spad_addr    = rd_addr_s;
    assign o_data         = data_q;
    assign o_addr         = addr_q;
    assign o_data_valid   = (state_q == ST_SEND);
    assign o_busy         = (state_q == ST_FETCH) || (state_q == ST_CAPTURE) || (state_q == ST_SEND);
    assign o_done         = (state_q == ST_DONE);
    assign o_word_count   = count_q;

endmodule

// File: tb/tb_tile_reader.sv
// Scoreboard bench for tile_reader: directed runs push expected words, a negedge
// monitor pops one entry per accepted broadcast and logs every scratchpad read.
module tb_tile_reader;

    typedef struct packed {
        logic [7:0]  a;
        logic [63:0] d;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_nrst = 1'b0;
    logic        i_reg_clear = 1'b0;
    logic        i_start = 1'b0;
    logic [7:0]  i_start_addr = 8'd0;
    logic [7:0]  i_end_addr = 8'd0;
    logic [3:0]  i_lane_en = 4'd0;
    logic [3:0]  i_lane_full = 4'd0;
    logic [3:0]  i_lane_route_done = 4'd0;
    logic        o_spad_read_en;
    logic [7:0]  o_spad_addr;
    logic [63:0] i_spad_data = 64'd0;
    logic [63:0] o_data;
    logic [7:0]  o_addr;
    logic        o_data_valid;
    logic        o_busy;
    logic        o_done;
    logic [7:0]  o_word_count;

    exp_t       sb[$];
    logic [7:0] rd_log[$];
    exp_t       mon_e;
    logic [3:0] mask_tb = 4'd0;
    int         total = 0;
    int         bad = 0;
    int         n;
    int         k;

    tile_reader dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_reg_clear(i_reg_clear), .i_start(i_start),
        .i_start_addr(i_start_addr), .i_end_addr(i_end_addr), .i_lane_en(i_lane_en),
        .i_lane_full(i_lane_full), .i_lane_route_done(i_lane_route_done),
        .o_spad_read_en(o_spad_read_en), .o_spad_addr(o_spad_addr), .i_spad_data(i_spad_data),
        .o_data(o_data), .o_addr(o_addr), .o_data_valid(o_data_valid), .o_busy(o_busy),
        .o_done(o_done), .o_word_count(o_word_count)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [63:0] spad_word(input logic [7:0] a);
        return {8{a}} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    // Scratchpad model: one-cycle read latency.
    always @(posedge i_clk) begin
        if (o_spad_read_en) i_spad_data <= spad_word(o_spad_addr);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop on every accepted broadcast, and log reads.
    always @(negedge i_clk) begin
        if (o_data_valid && !(|(i_lane_full & mask_tb))) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got addr %0d expected none", o_addr);
            end else begin
                mon_e = sb.pop_front();
                check("word_addr", {56'd0, o_addr}, {56'd0, mon_e.a});
                check("word_data", o_data, mon_e.d);
            end
        end
        if (o_spad_read_en) rd_log.push_back(o_spad_addr);
    end

    task automatic expect_range(input int s, input int e);
        for (int a = s; a <= e; a++) begin
            sb.push_back({a[7:0], spad_word(a[7:0])});
        end
    endtask

    task automatic start_run(input logic [7:0] s, input logic [7:0] e, input logic [3:0] m);
        @(posedge i_clk); #1;
        i_start = 1'b1; i_start_addr = s; i_end_addr = e; i_lane_en = m; mask_tb = m;
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!o_done && cyc < 200) begin
            @(negedge i_clk);
            cyc++;
        end
        if (!o_done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got busy after %0d cycles expected done", cyc);
        end
    endtask

    task automatic check_reads(input string name, input int s, input int cnt);
        check({name, "_nreads"}, 64'(rd_log.size()), 64'(cnt));
        for (int i = 0; i < cnt && i < rd_log.size(); i++) begin
            check({name, "_read"}, {56'd0, rd_log[i]}, 64'(s + i));
        end
    endtask

    initial begin
        repeat (3) @(posedge i_clk);
        #1 i_nrst = 1'b1;
        @(negedge i_clk);
        check("rst_valid", {63'd0, o_data_valid}, 64'd0);
        check("rst_busy", {63'd0, o_busy}, 64'd0);
        check("rst_done", {63'd0, o_done}, 64'd0);
        check("rst_count", {56'd0, o_word_count}, 64'd0);
        check("rst_rden", {63'd0, o_spad_read_en}, 64'd0);

        // Basic run 2..4
        rd_log.delete();
        expect_range(2, 4);
        start_run(8'd2, 8'd4, 4'hF);
        wait_done(n);
        check("basic_cycles", 64'(n), 64'd8);
        check("basic_count", {56'd0, o_word_count}, 64'd3);
        check_reads("basic", 2, 3);
        repeat (3) @(negedge i_clk);
        check("basic_done_hold", {63'd0, o_done}, 64'd1);
        check("basic_drain", 64'(sb.size()), 64'd0);

        // Stall on word 1 with a start pulse mid-run
        rd_log.delete();
        expect_range(0, 3);
        start_run(8'd0, 8'd3, 4'hF);
        k = 0;
        do begin @(negedge i_clk); k++; end while (!(o_spad_read_en && o_spad_addr == 8'd1) && k < 50);
        @(posedge i_clk); #1 i_lane_full = 4'b0010;
        for (int c = 1; c <= 3; c++) begin
            @(posedge i_clk); #1;
            if (c == 2) begin i_start = 1'b1; i_start_addr = 8'd9; i_end_addr = 8'd9; end
            if (c == 3) i_start = 1'b0;
            @(negedge i_clk);
            check("stall_valid", {63'd0, o_data_valid}, 64'd1);
            check("stall_addr", {56'd0, o_addr}, 64'd1);
            check("stall_data", o_data, spad_word(8'd1));
            check("stall_rden", {63'd0, o_spad_read_en}, 64'd0);
        end
        @(posedge i_clk); #1 i_lane_full = 4'b0000;
        @(negedge i_clk);
        check("release_rden", {63'd0, o_spad_read_en}, 64'd1);
        check("release_raddr", {56'd0, o_spad_addr}, 64'd2);
        wait_done(n);
        check("stall_count", {56'd0, o_word_count}, 64'd4);
        check_reads("stall", 0, 4);
        check("stall_drain", 64'(sb.size()), 64'd0);

        // Masked stall: full lane is disabled
        rd_log.delete();
        i_lane_full = 4'b0010;
        expect_range(6, 8);
        start_run(8'd6, 8'd8, 4'b0101);
        wait_done(n);
        check("mstall_cycles", 64'(n), 64'd8);
        check("mstall_count", {56'd0, o_word_count}, 64'd3);
        check("mstall_drain", 64'(sb.size()), 64'd0);
        i_lane_full = 4'b0000;

        // Early done at word 5
        rd_log.delete();
        expect_range(0, 5);
        start_run(8'd0, 8'd10, 4'hF);
        k = 0;
        do begin @(negedge i_clk); k++; end while (!(o_data_valid && o_addr == 8'd5) && k < 100);
        i_lane_route_done = 4'hF;
        wait_done(n);
        check("early_count", {56'd0, o_word_count}, 64'd6);
        check_reads("early", 0, 6);
        check("early_drain", 64'(sb.size()), 64'd0);
        i_lane_route_done = 4'h0;

        // Empty range
        rd_log.delete();
        start_run(8'd5, 8'd3, 4'hF);
        check("empty_done", {63'd0, o_done}, 64'd1);
        check("empty_count", {56'd0, o_word_count}, 64'd0);
        repeat (2) @(negedge i_clk);
        check("empty_nreads", 64'(rd_log.size()), 64'd0);

        // Top-of-range single word
        rd_log.delete();
        expect_range(255, 255);
        start_run(8'd255, 8'd255, 4'hF);
        wait_done(n);
        check("top_count", {56'd0, o_word_count}, 64'd1);
        check_reads("top", 255, 1);
        check("top_drain", 64'(sb.size()), 64'd0);

        // Async reset during CAPTURE
        start_run(8'd0, 8'd3, 4'hF);
        k = 0;
        do begin @(negedge i_clk); k++; end while (!o_spad_read_en && k < 20);
        @(posedge i_clk); #1 i_nrst = 1'b0;
        #1;
        check("arst_data", o_data, 64'd0);
        check("arst_addr", {56'd0, o_addr}, 64'd0);
        check("arst_busy", {63'd0, o_busy}, 64'd0);
        check("arst_valid", {63'd0, o_data_valid}, 64'd0);
        check("arst_rden", {63'd0, o_spad_read_en}, 64'd0);
        check("arst_count", {56'd0, o_word_count}, 64'd0);
        @(posedge i_clk); #1 i_nrst = 1'b1;

        // Synchronous clear during SEND
        sb.push_back({8'd0, spad_word(8'd0)});
        start_run(8'd0, 8'd3, 4'hF);
        k = 0;
        do begin @(negedge i_clk); k++; end while (!o_data_valid && k < 20);
        i_reg_clear = 1'b1;
        @(posedge i_clk); #1 i_reg_clear = 1'b0;
        check("clr_valid", {63'd0, o_data_valid}, 64'd0);
        check("clr_busy", {63'd0, o_busy}, 64'd0);
        check("clr_done", {63'd0, o_done}, 64'd0);
        check("clr_data", o_data, 64'd0);
        repeat (3) @(negedge i_clk);
        check("clr_idle", {63'd0, o_busy}, 64'd0);
        check("final_drain", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tile_reader.md
Name: tile_reader

Overview:
- Transmitter side of the scratchpad-to-lane broadcast interface.
- Walks an inclusive range of scratchpad word addresses and issues synchronous reads.
- Presents each word with its word address to all row/column data lanes at once.
- Holds a word until no enabled lane reports full, and stops early once every enabled lane reports its route done.

Parameters:
- SPAD_DATA_WIDTH, 64, scratchpad word width in bits.
- DATA_WIDTH, 8, element width in bits.
- ADDR_WIDTH, 8, scratchpad word address width.
- SPAD_N, SPAD_DATA_WIDTH/DATA_WIDTH, elements per word (informational, derived).
- N_LANES, 4, number of data lanes fed.

Ports:
- i_clk  in  1  clock.
- i_nrst  in  1  asynchronous active-low reset.
- i_reg_clear  in  1  synchronous clear to IDLE.
- i_start  in  1  start pulse; sampled only in IDLE or DONE.
- i_start_addr  in  ADDR_WIDTH  first word address, inclusive.
- i_end_addr  in  ADDR_WIDTH  last word address, inclusive.
- i_lane_en  in  N_LANES  lane enable mask; sampled on start.
- i_lane_full  in  N_LANES  per-lane MISO full / not-enough-slots.
- i_lane_route_done  in  N_LANES  per-lane route done.
- o_spad_read_en  out  1  scratchpad read strobe.
- o_spad_addr  out  ADDR_WIDTH  scratchpad read address.
- i_spad_data  in  SPAD_DATA_WIDTH  read data, valid 1 cycle after o_spad_read_en.
- o_data  out  SPAD_DATA_WIDTH  broadcast word.
- o_addr  out  ADDR_WIDTH  word address of o_data.
- o_data_valid  out  1  broadcast valid.
- o_busy  out  1  high in FETCH/CAPTURE/SEND.
- o_done  out  1  high in DONE.
- o_word_count  out  ADDR_WIDTH  words accepted this run.

Behaviour:
- Reset: i_nrst low asynchronously forces state IDLE. All outputs 0. Internal ptr, end and mask registers 0.
- i_reg_clear: same effect as reset, applied synchronously. Has priority over every other event.
- Accept condition in SEND: o_data_valid & ~|(i_lane_full & lane_mask).
- Lanes gate their own writes on slot availability, so the word, o_addr and o_data_valid must stay stable until accepted.
- All-done condition: &(i_lane_route_done | ~lane_mask). A mask of all zeros counts as all-done.
- IDLE:
  - On i_start, latch start, end and mask; set ptr=start; clear o_word_count.
  - If start>end, go to DONE; no read is ever issued.
  - Otherwise go to FETCH.
- FETCH:
  - If all-done, go to DONE without reading.
  - Otherwise assert o_spad_read_en with o_spad_addr=ptr and go to CAPTURE.
- CAPTURE: register i_spad_data into o_data and ptr into o_addr, then go to SEND. o_data_valid rises in the next cycle.
- SEND: o_data_valid=1.
  - No accept: stay in SEND. No read is issued; data and address are held.
  - Accept: o_word_count++.
    - If o_addr==end, go to DONE.
    - Otherwise ptr++. If all-done is already true this cycle, go to DONE.
    - Otherwise, in the same cycle, assert o_spad_read_en with o_spad_addr=ptr+1 and go to CAPTURE.
  - Steady-state throughput is 1 word per 2 cycles.
- DONE:
  - o_done=1, o_data_valid=0.
  - i_start restarts exactly as from IDLE, taking the start>end shortcut when it applies.
  - Remains in DONE until i_start or i_reg_clear.
- i_start while o_busy is ignored.
- Address arithmetic:
  - The comparison o_addr==end is an exact match and is made before the increment.
  - ptr never wraps. end=2^ADDR_WIDTH-1 terminates on the last word without overflow.
- The lane masks are lane_mask from start onward. Lanes that are disabled are ignored for both full and route_done.
- o_spad_read_en is never asserted in IDLE, DONE, or a stalled SEND.

Test Plan:
- Basic run: start=2, end=4, mask=4'b1111, full=0, route_done=0 -> reads at addresses 2, 3, 4. o_data_valid goes high for one cycle on alternating cycles with o_addr=2, 3, 4 and o_data equal to the scratchpad contents. DONE follows; o_word_count=3; o_done stays high.
- Stall: start=0, end=3; assert i_lane_full[1] for 3 cycles while word 1 is in SEND -> o_data_valid is held for 4 cycles. o_data and o_addr=1 stay stable and no read_en is seen. The read of address 2 is issued in the release cycle.
- Masked stall: mask=4'b0101 and i_lane_full[1]=1 throughout -> the run completes as if there were no stall.
- Early done: start=0, end=10; all enabled lanes raise route_done at the accept of word 5 -> no read of address 6. DONE is reached with o_word_count=6.
- Empty range: start=5, end=3 -> o_spad_read_en is never asserted and o_done is high 1 cycle after start, with o_word_count=0.
- Boundary and clear cases:
  - start=end=255 -> exactly one word; address 255 is sent and there is no wrap.
  - i_reg_clear pulsed during SEND -> IDLE next cycle with o_data_valid=0.
  - i_start pulsed mid-run is ignored.
  - i_nrst asserted mid-CAPTURE -> all outputs 0 immediately.
